delay_meter: RTL and testbench

- Synthesizable response-side companion to our gate-structure stimulus benches.
- Drives one stimulus bit into a gate structure under test and times, in clock cycles, how long the structure's output takes to respond to each stimulus edge.
- Captures both the to-1 (rise) and to-0 (fall) response delays in one run.
- Flags timeouts and wrong idle levels, so worst-case delays are measured on hardware instead of read off waveforms.

---
 rtl/delay_meter_if.sv | 39 +++
 rtl/delay_meter.sv | 161 ++++++++++++++++
 tb/tb_delay_meter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_meter_if.sv
// delay_meter bus: start/stimulus/response and result signals.
// master = controller and structure under test, slave = delay_meter.
interface delay_meter_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             dut_in;
  logic             stim_out;
  logic [CNT_W-1:0] rise_dly;
  logic [CNT_W-1:0] fall_dly;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic             level_err;

  modport master (
    output start,
    output dut_in,
    input  stim_out,
    input  rise_dly,
    input  fall_dly,
    input  busy,
    input  done,
    input  timeout_err,
    input  level_err
  );

  modport slave (
    input  start,
    input  dut_in,
    output stim_out,
    output rise_dly,
    output fall_dly,
    output busy,
    output done,
    output timeout_err,
    output level_err
  );
endinterface

// File: rtl/delay_meter.sv
// delay_meter: times rise/fall response delays of a gate structure.
// Optional macro DELAY_METER_SYNC_EN adds a 2-flop input synchronizer.
module delay_meter #(
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 200,
  parameter int SETTLE   = 4,
  parameter bit INIT_LVL = 1'b1,
  parameter bit INVERT   = 1'b1
) (
  input logic        clk,
  input logic        rst,
  delay_meter_if.slave bus
);

  localparam logic L_RESP0 = INIT_LVL ^ INVERT;
  localparam logic [CNT_W-1:0] L_TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_ST_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEAS1,
    S_GAP,
    S_MEAS2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stim;
  logic [CNT_W-1:0] r_rise;
  logic [CNT_W-1:0] r_fall;
  logic             r_busy;
  logic             r_done;
  logic             r_to;
  logic             r_lvl;
  logic             w_rsp;

`ifdef DELAY_METER_SYNC_EN
  logic [1:0] r_sync;

  // two-flop synchronizer, idles at the expected response level
  always_ff @(posedge clk) begin
    if (rst) r_sync <= {2{L_RESP0}};
    else     r_sync <= {r_sync[0], bus.dut_in};
  end

  assign w_rsp = r_sync[1];
`else
  assign w_rsp = bus.dut_in;
`endif

  // measurement sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stim  <= INIT_LVL;
      r_rise  <= '0;
      r_fall  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
      r_lvl   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_to    <= 1'b0;
            r_lvl   <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == L_ST_LAST) begin
            r_cnt <= '0;
            if (w_rsp != L_RESP0) begin
              r_lvl   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_stim  <= ~INIT_LVL;
              r_state <= S_MEAS1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_MEAS1: begin
          if (w_rsp == ~L_RESP0) begin
            if (L_RESP0) r_fall <= r_cnt;
            else         r_rise <= r_cnt;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else if (r_cnt == L_TO_LAST) begin
            if (L_RESP0) r_fall <= '1;
            else         r_rise <= '1;
            r_to    <= 1'b1;
            r_stim  <= INIT_LVL;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == L_ST_LAST) begin
            r_stim  <= INIT_LVL;
            r_cnt   <= '0;
            r_state <= S_MEAS2;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_MEAS2: begin
          if (w_rsp == L_RESP0) begin
            if (L_RESP0) r_rise <= r_cnt;
            else         r_fall <= r_cnt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt == L_TO_LAST) begin
            if (L_RESP0) r_rise <= '1;
            else         r_fall <= '1;
            r_to    <= 1'b1;
            r_stim  <= INIT_LVL;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_stim  <= INIT_LVL;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stim_out    = r_stim;
  assign bus.rise_dly    = r_rise;
  assign bus.fall_dly    = r_fall;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_to;
  assign bus.level_err   = r_lvl;

endmodule

// File: tb/tb_delay_meter.sv
// Bench for delay_meter: modelled delay structure, scoreboard + monitor.
// Works with DELAY_METER_SYNC_EN defined or undefined.
module tb_delay_meter;

  localparam int CNT_W    = 8;
  localparam int TIMEOUT  = 200;
  localparam int SETTLE   = 4;
  localparam bit INIT_LVL = 1'b1;
  localparam bit INVERT   = 1'b1;
  localparam bit RESP0    = INIT_LVL ^ INVERT;
`ifdef DELAY_METER_SYNC_EN
  localparam int OFS = 2;
`else
  localparam int OFS = 0;
`endif

  typedef struct {
    int rise;
    int fall;
    int to;
    int lvl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  delay_meter_if #(.CNT_W(CNT_W)) bus();

  delay_meter #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE),
    .INIT_LVL(INIT_LVL), .INVERT(INVERT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // structure under test: 0 = delay line, 1 = stuck resp0, 2 = stuck ~resp0
  int mode = 0;
  int dr = 0;
  int df = 0;
  int last_max = 0;

  initial begin
    int  pend;
    logic tgt;
    pend = 0;
    bus.dut_in = RESP0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        bus.dut_in = RESP0;
        pend = 0;
      end else if (mode == 2) begin
        bus.dut_in = ~RESP0;
        pend = 0;
      end else begin
        tgt = bus.stim_out ^ INVERT;
        if (tgt == bus.dut_in) pend = 0;
        else begin
          pend++;
          if (pend > (tgt ? dr : df)) begin
            bus.dut_in = tgt;
            pend = 0;
          end
        end
      end
    end
  end

  // reference: one measured direction from its structure delay
  function automatic int meas(input int d);
    if (d + OFS >= TIMEOUT) return (1 << CNT_W) - 1;
    return d + OFS;
  endfunction

  function automatic exp_t model(input int m, input int r, input int f);
    exp_t e;
    int   d1, d2, m1, m2;
    e.rise = 0; e.fall = 0; e.to = 0; e.lvl = 0;
    if (m == 2) begin
      e.lvl = 1;
      return e;
    end
    d1 = RESP0 ? f : r;
    d2 = RESP0 ? r : f;
    if (m == 1) d1 = TIMEOUT;
    m1 = meas(d1);
    m2 = 0;
    if (m1 == (1 << CNT_W) - 1) e.to = 1;
    else begin
      m2 = meas(d2);
      if (m2 == (1 << CNT_W) - 1) e.to = 1;
    end
    if (RESP0) begin e.fall = m1; e.rise = m2; end
    else       begin e.rise = m1; e.fall = m2; end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // pre-edge samples for the monitor
  logic s_rst = 1'b0;
  logic s_acc = 1'b0;
  initial forever begin
    @(posedge clk);
    s_rst <= rst;
    s_acc <= bus.start && !bus.busy && !rst;
  end

  // monitor: reset values, start acceptance, and scoreboard on done
  initial begin
    logic prev_done;
    int   wait_cyc;
    exp_t e;
    prev_done = 1'b0;
    wait_cyc = 0;
    forever begin
      @(negedge clk);
      if (s_rst) begin
        chk("reset", int'({bus.stim_out, bus.rise_dly, bus.fall_dly,
            bus.busy, bus.done, bus.timeout_err, bus.level_err}),
            int'({INIT_LVL, 20'd0}));
      end else begin
        if (s_acc)
          chk("accept", int'({bus.busy, bus.done, bus.timeout_err,
              bus.level_err, bus.rise_dly, bus.fall_dly}),
              int'({1'b1, 19'd0}));
        if (bus.done && !prev_done) begin
          wait_cyc = 0;
          if (q.size() == 0) chk("spurious_done", 1, 0);
          else begin
            e = q.pop_front();
            chk("rise_dly", int'(bus.rise_dly), e.rise);
            chk("fall_dly", int'(bus.fall_dly), e.fall);
            chk("timeout_err", int'(bus.timeout_err), e.to);
            chk("level_err", int'(bus.level_err), e.lvl);
            chk("stim_end", int'(bus.stim_out), int'(INIT_LVL));
            chk("busy_end", int'(bus.busy), 0);
          end
        end else if (q.size() > 0) begin
          wait_cyc++;
          if (wait_cyc > 3000) begin
            chk("done_wait", 0, 1);
            void'(q.pop_front());
            wait_cyc = 0;
          end
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !bus.done; i++) @(negedge clk);
  endtask

  task automatic wait_stim(input logic lvl);
    for (int i = 0; i < 1000 && bus.stim_out != lvl; i++)
      @(negedge clk);
  endtask

  task automatic prep(input int m, input int r, input int f);
    int mx;
    mode = m; dr = r; df = f;
    mx = (r > f) ? r : f;
    idle(((mx > last_max) ? mx : last_max) + OFS + SETTLE + 12);
    last_max = mx;
  endtask

  task automatic run(input int m, input int r, input int f,
                     input bit restart);
    prep(m, r, f);
    q.push_back(model(m, r, f));
    pulse_start();
    if (restart) begin
      wait_stim(~INIT_LVL);
      idle(3);
      pulse_start();
    end
    wait_done();
    idle(2);
  endtask

  initial begin
    bus.start = 1'b0;
    idle(4);
    rst = 1'b0;
    idle(3);

    run(0, 0, 0, 1'b0);
    run(0, 10, 3, 1'b0);
    run(1, 0, 0, 1'b0);
    run(2, 0, 0, 1'b0);
    run(0, 10, 10, 1'b1);
    run(0, TIMEOUT - 1 - OFS, 3, 1'b0);
    run(0, TIMEOUT - OFS, 3, 1'b0);
    run(0, 2, TIMEOUT - 1 - OFS, 1'b0);
    run(0, 2, TIMEOUT - OFS, 1'b0);

    prep(0, 20, 20);
    pulse_start();
    wait_stim(~INIT_LVL);
    wait_stim(INIT_LVL);
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    for (int k = 0; k < 25; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      run(1, 0, 0, 1'b0);
      else if (sel == 1) run(2, 0, 0, 1'b0);
      else run(0, $urandom_range(0, 40), $urandom_range(0, 40),
               ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 5000 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
